// File: rtl/lcd_pattern_pkg.sv
// ============================================================================
// Module      : lcd_pattern_pkg
// Description : Shared definitions for the LCD test-pattern source: pattern
//               mode encodings, RGB565/RGB332 component widths, colour packing
//               helpers and the colour-bar table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pattern_pkg;

  // Pattern modes selectable with the next/prev buttons
  typedef enum logic [2:0] {
    MODE_CHECKER  = 3'd0,
    MODE_BARS     = 3'd1,
    MODE_GRADIENT = 3'd2,
    MODE_SOLID    = 3'd3,
    MODE_GRID     = 3'd4
  } mode_e;

  localparam logic [2:0] MODE_FIRST = 3'd0;
  localparam logic [2:0] MODE_LAST  = 3'd4;

  // Component widths of the two supported pixel formats
  localparam int RGB565_R_BITS = 5;
  localparam int RGB565_G_BITS = 6;
  localparam int RGB565_B_BITS = 5;
  localparam int RGB332_R_BITS = 3;
  localparam int RGB332_G_BITS = 3;
  localparam int RGB332_B_BITS = 2;

  // Colour bars, left to right, as {R,G,B} full-scale enables.
  // Index 0 (leftmost bar) sits in the least significant slot.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000,   // 7 black
    3'b001,   // 6 blue
    3'b100,   // 5 red
    3'b101,   // 4 magenta
    3'b010,   // 3 green
    3'b011,   // 2 cyan
    3'b110,   // 1 yellow
    3'b111    // 0 white
  };

  // Components arrive as 8-bit MSB-aligned values; packing keeps the MSBs.
  function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
    return {r[7 -: RGB565_R_BITS], g[7 -: RGB565_G_BITS], b[7 -: RGB565_B_BITS]};
  endfunction

  function automatic logic [7:0] pack_rgb332(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    return {r[7 -: RGB332_R_BITS], g[7 -: RGB332_G_BITS], b[7 -: RGB332_B_BITS]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_btn_debounce.sv
// ============================================================================
// Module      : lcd_btn_debounce
// Description : Raw button conditioner: 2-FF synchroniser, saturating
//               stable-level counter and one-cycle press pulse on the
//               debounced rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_btn_debounce #(
  parameter int C_DEBOUNCE_BITS = 16
) (
  input  logic clk_i,
  input  logic resn_i,
  input  logic btn_i,
  output logic press_o
);

  logic                       sync1_q;
  logic                       sync2_q;
  logic                       state_q;
  logic                       state_d;
  logic [C_DEBOUNCE_BITS-1:0] cnt_q;
  logic [C_DEBOUNCE_BITS-1:0] cnt_d;

  // Count while the synchronised level disagrees with the debounced state;
  // accept the new level once the counter has reached all-ones.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      state_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + C_DEBOUNCE_BITS'(1);
    end
  end

  // The pulse is asserted in the cycle the state is about to rise, so the
  // consumer registers it on the same edge as the debounced state.
  assign press_o = state_d & ~state_q;

  // Synchroniser, debounced state and stability counter
  always_ff @(posedge clk_i or negedge resn_i) begin
    if (!resn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_pattern_gen.sv
// ============================================================================
// Module      : lcd_pattern_gen
// Description : Parametrised test-pattern source for the SPI LCD path.
//               Answers (x, y) pixel requests combinationally with a colour
//               word; mode is stepped by debounced next/prev buttons; a frame
//               tick marks each return to (0,0).
//               Optional feature macro: LCD_PATTERN_SCROLL_EN - when defined,
//               the pattern scrolls horizontally by one pixel every
//               C_FRAME_DIV frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_pattern_gen
  import lcd_pattern_pkg::*;
#(
  parameter int C_X_BITS        = 8,
  parameter int C_Y_BITS        = 8,
  parameter int C_COLOR_BITS    = 16,
  parameter int C_CHECKER_LOG2  = 4,
  parameter int C_DEBOUNCE_BITS = 16,
  parameter int C_FRAME_DIV     = 2
) (
  input  logic                    clk_i,
  input  logic                    resn_i,
  input  logic                    btn_next_i,
  input  logic                    btn_prev_i,
  input  logic [C_X_BITS-1:0]     x_i,
  input  logic [C_Y_BITS-1:0]     y_i,
  output logic [C_COLOR_BITS-1:0] color_o,
  output logic [2:0]              mode_o,
  output logic                    frame_tick_o
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (C_CHECKER_LOG2 < 1 || C_CHECKER_LOG2 >= C_X_BITS || C_CHECKER_LOG2 >= C_Y_BITS) begin : g_bad_checker
    $error("lcd_pattern_gen: C_CHECKER_LOG2 must be in 1..min(C_X_BITS,C_Y_BITS)-1");
  end
  if (C_FRAME_DIV < 1 || C_FRAME_DIV > 255) begin : g_bad_frame_div
    $error("lcd_pattern_gen: C_FRAME_DIV must be in 1..255");
  end
  if (C_DEBOUNCE_BITS < 1) begin : g_bad_debounce
    $error("lcd_pattern_gen: C_DEBOUNCE_BITS must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Buttons
  // --------------------------------------------------------------------------
  logic w_next_press;
  logic w_prev_press;

  lcd_btn_debounce #(
    .C_DEBOUNCE_BITS (C_DEBOUNCE_BITS)
  ) u_btn_next (
    .clk_i   (clk_i),
    .resn_i  (resn_i),
    .btn_i   (btn_next_i),
    .press_o (w_next_press)
  );

  lcd_btn_debounce #(
    .C_DEBOUNCE_BITS (C_DEBOUNCE_BITS)
  ) u_btn_prev (
    .clk_i   (clk_i),
    .resn_i  (resn_i),
    .btn_i   (btn_prev_i),
    .press_o (w_prev_press)
  );

  // --------------------------------------------------------------------------
  // Mode register
  // --------------------------------------------------------------------------
  logic [2:0] mode_q;
  logic [2:0] mode_d;
  logic       w_mode_change;

  // Step the mode with wrap-around; simultaneous presses cancel out
  always_comb begin
    mode_d = mode_q;
    if (w_next_press && !w_prev_press) begin
      mode_d = (mode_q == MODE_LAST) ? MODE_FIRST : mode_q + 3'd1;
    end else if (w_prev_press && !w_next_press) begin
      mode_d = (mode_q == MODE_FIRST) ? MODE_LAST : mode_q - 3'd1;
    end
  end

  assign w_mode_change = (mode_d != mode_q);

  // Registered pattern mode
  always_ff @(posedge clk_i or negedge resn_i) begin
    if (!resn_i) begin
      mode_q <= MODE_FIRST;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign mode_o = mode_q;

  // --------------------------------------------------------------------------
  // Frame detection
  // --------------------------------------------------------------------------
  logic [C_X_BITS-1:0] prev_x_q;
  logic [C_Y_BITS-1:0] prev_y_q;
  logic                w_origin;
  logic                w_prev_origin;

  // Remember the previous request so a held (0,0) ticks only once
  always_ff @(posedge clk_i or negedge resn_i) begin
    if (!resn_i) begin
      prev_x_q <= '0;
      prev_y_q <= '0;
    end else begin
      prev_x_q <= x_i;
      prev_y_q <= y_i;
    end
  end

  assign w_origin      = (x_i == '0) && (y_i == '0);
  assign w_prev_origin = (prev_x_q == '0) && (prev_y_q == '0);
  assign frame_tick_o  = w_origin & ~w_prev_origin;

  // --------------------------------------------------------------------------
  // Horizontal scroll offset
  // --------------------------------------------------------------------------
  logic [C_X_BITS-1:0] w_offset;

`ifdef LCD_PATTERN_SCROLL_EN
  logic [7:0]          div_q;
  logic [C_X_BITS-1:0] offset_q;

  // Advance the offset every C_FRAME_DIV frames; a new mode restarts from 0
  always_ff @(posedge clk_i or negedge resn_i) begin
    if (!resn_i) begin
      div_q    <= '0;
      offset_q <= '0;
    end else if (w_mode_change) begin
      div_q    <= '0;
      offset_q <= '0;
    end else if (frame_tick_o) begin
      if (div_q == 8'(C_FRAME_DIV - 1)) begin
        div_q    <= '0;
        offset_q <= offset_q + C_X_BITS'(1);
      end else begin
        div_q <= div_q + 8'd1;
      end
    end
  end

  assign w_offset = offset_q;
`else
  // Static patterns: the mode-change strobe has no consumer here
  logic w_unused_mode_change;
  assign w_unused_mode_change = w_mode_change;
  assign w_offset             = '0;
`endif

  // --------------------------------------------------------------------------
  // Pattern generation
  // --------------------------------------------------------------------------
  logic [C_X_BITS-1:0] w_xs;
  logic [7:0]          w_xs_top;
  logic [7:0]          w_x_top;
  logic [7:0]          w_y_top;
  logic [2:0]          w_bar;
  logic [7:0]          w_r;
  logic [7:0]          w_g;
  logic [7:0]          w_b;

  assign w_xs = x_i + w_offset;

  // MSB-aligned 8-bit views of the coordinates; narrow ones are zero-padded
  if (C_X_BITS >= 8) begin : g_x_msb
    assign w_xs_top = w_xs[C_X_BITS-1 -: 8];
    assign w_x_top  = x_i[C_X_BITS-1 -: 8];
  end else begin : g_x_pad
    assign w_xs_top = {w_xs, {(8-C_X_BITS){1'b0}}};
    assign w_x_top  = {x_i,  {(8-C_X_BITS){1'b0}}};
  end

  if (C_Y_BITS >= 8) begin : g_y_msb
    assign w_y_top = y_i[C_Y_BITS-1 -: 8];
  end else begin : g_y_pad
    assign w_y_top = {y_i, {(8-C_Y_BITS){1'b0}}};
  end

  assign w_bar = BAR_RGB[w_xs_top[7:5]];

  // Per-mode colour components; unknown modes render black
  always_comb begin
    w_r = 8'h00;
    w_g = 8'h00;
    w_b = 8'h00;
    case (mode_e'(mode_q))
      MODE_CHECKER: begin
        if (w_xs[C_CHECKER_LOG2] ^ y_i[C_CHECKER_LOG2]) begin
          w_g = w_xs_top;
        end else begin
          w_r = w_y_top;
        end
      end
      MODE_BARS: begin
        w_r = {8{w_bar[2]}};
        w_g = {8{w_bar[1]}};
        w_b = {8{w_bar[0]}};
      end
      MODE_GRADIENT: begin
        w_r = w_x_top;
        w_g = w_y_top;
      end
      MODE_SOLID: begin
        w_r = 8'hFF;
        w_g = 8'hFF;
        w_b = 8'hFF;
      end
      MODE_GRID: begin
        if ((w_xs[C_CHECKER_LOG2-1:0] == '0) || (y_i[C_CHECKER_LOG2-1:0] == '0)) begin
          w_r = 8'hFF;
          w_g = 8'hFF;
          w_b = 8'hFF;
        end
      end
      default: begin
        w_r = 8'h00;
        w_g = 8'h00;
        w_b = 8'h00;
      end
    endcase
  end

  // Pack into the configured pixel format
  if (C_COLOR_BITS == 16) begin : g_rgb565
    assign color_o = pack_rgb565(w_r, w_g, w_b);
  end else if (C_COLOR_BITS == 8) begin : g_rgb332
    assign color_o = pack_rgb332(w_r, w_g, w_b);
  end else begin : g_bad_color
    $error("lcd_pattern_gen: C_COLOR_BITS must be 16 (RGB565) or 8 (RGB332)");
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_pattern_gen.sv
// ============================================================================
// Module      : tb_lcd_pattern_gen
// Description : Directed self-checking bench for lcd_pattern_gen (RGB565,
//               8-bit coordinates, 4-bit debounce counter, C_FRAME_DIV=2).
//               Expectations follow LCD_PATTERN_SCROLL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_pattern_gen;

  logic        clk;
  logic        resn;
  logic        btn_next;
  logic        btn_prev;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] color;
  logic [2:0]  mode;
  logic        frame_tick;

  int vectors;
  int miscompares;

  lcd_pattern_gen #(
    .C_X_BITS        (8),
    .C_Y_BITS        (8),
    .C_COLOR_BITS    (16),
    .C_CHECKER_LOG2  (4),
    .C_DEBOUNCE_BITS (4),
    .C_FRAME_DIV     (2)
  ) dut (
    .clk_i        (clk),
    .resn_i       (resn),
    .btn_next_i   (btn_next),
    .btn_prev_i   (btn_prev),
    .x_i          (x),
    .y_i          (y),
    .color_o      (color),
    .mode_o       (mode),
    .frame_tick_o (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clean button presses, long enough for the 16-clock debounce both ways
  task automatic press_next();
    @(negedge clk); btn_next = 1'b1;
    repeat (24) @(negedge clk);
    btn_next = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic press_prev();
    @(negedge clk); btn_prev = 1'b1;
    repeat (24) @(negedge clk);
    btn_prev = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic test_reset();
    resn = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; x = 8'd0; y = 8'd0;
    #1;
    vectors++;
    if (mode !== 3'd0) begin miscompares++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    vectors++;
    if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    x = 8'd16; y = 8'd16; #1;
    vectors++;
    if (color !== 16'h1000) begin miscompares++; $display("FAIL reset_color_16_16: got %h expected 1000", color); end
    repeat (3) @(negedge clk);
    resn = 1'b1;
    x = 8'd100; y = 8'd100;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 20; i++) begin
      btn_next = ~btn_next;
      repeat (5) @(negedge clk);
    end
    vectors++;
    if (mode !== 3'd0) begin miscompares++; $display("FAIL bounce_no_step: got %0d expected 0", mode); end
    btn_next = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    vectors++;
    if (mode !== 3'd0) begin miscompares++; $display("FAIL debounce_early: got %0d expected 0", mode); end
    @(posedge clk); #1;
    vectors++;
    if (mode !== 3'd1) begin miscompares++; $display("FAIL debounce_step: got %0d expected 1", mode); end
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (mode !== 3'd1) begin miscompares++; $display("FAIL release_no_step: got %0d expected 1", mode); end
    for (int k = 1; k <= 4; k++) begin
      press_next();
      vectors++;
      if (mode !== 3'((1 + k) % 5)) begin
        miscompares++;
        $display("FAIL next_press_%0d: got %0d expected %0d", k, mode, (1 + k) % 5);
      end
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk); btn_next = 1'b1; btn_prev = 1'b1;
    repeat (24) @(negedge clk);
    vectors++;
    if (mode !== 3'd0) begin miscompares++; $display("FAIL simul_press: got %0d expected 0", mode); end
    btn_next = 1'b0; btn_prev = 1'b0;
    repeat (24) @(negedge clk);
    vectors++;
    if (mode !== 3'd0) begin miscompares++; $display("FAIL simul_release: got %0d expected 0", mode); end
    press_prev();
    vectors++;
    if (mode !== 3'd4) begin miscompares++; $display("FAIL prev_wrap: got %0d expected 4", mode); end
    press_next();
    vectors++;
    if (mode !== 3'd0) begin miscompares++; $display("FAIL next_wrap: got %0d expected 0", mode); end
  endtask

  task automatic test_patterns();
    // mode 0 checkered
    @(negedge clk); x = 8'd32; y = 8'd16; #1;
    vectors++;
    if (color !== 16'h0100) begin miscompares++; $display("FAIL checker_32_16: got %h expected 0100", color); end
    // mode 1 bars
    press_next();
    x = 8'd0; y = 8'd5; #1;
    vectors++;
    if (color !== 16'hFFFF) begin miscompares++; $display("FAIL bars_x0: got %h expected FFFF", color); end
    x = 8'd32; #1;
    vectors++;
    if (color !== 16'hFFE0) begin miscompares++; $display("FAIL bars_x32: got %h expected FFE0", color); end
    x = 8'd224; #1;
    vectors++;
    if (color !== 16'h0000) begin miscompares++; $display("FAIL bars_x224: got %h expected 0000", color); end
    // mode 2 gradient
    press_next();
    x = 8'd128; y = 8'd64; #1;
    vectors++;
    if (color !== 16'h8200) begin miscompares++; $display("FAIL gradient_128_64: got %h expected 8200", color); end
    // mode 3 solid
    press_next();
    x = 8'd77; y = 8'd33; #1;
    vectors++;
    if (color !== 16'hFFFF) begin miscompares++; $display("FAIL solid: got %h expected FFFF", color); end
    // mode 4 grid
    press_next();
    x = 8'd16; y = 8'd5; #1;
    vectors++;
    if (color !== 16'hFFFF) begin miscompares++; $display("FAIL grid_16_5: got %h expected FFFF", color); end
    x = 8'd17; #1;
    vectors++;
    if (color !== 16'h0000) begin miscompares++; $display("FAIL grid_17_5: got %h expected 0000", color); end
    vectors++;
    if (mode !== 3'd4) begin miscompares++; $display("FAIL mode_after_patterns: got %0d expected 4", mode); end
  endtask

  task automatic test_reset_midframe();
    press_prev();
    vectors++;
    if (mode !== 3'd3) begin miscompares++; $display("FAIL pre_reset_mode: got %0d expected 3", mode); end
    @(negedge clk); x = 8'd50; y = 8'd7;
    #2 resn = 1'b0;
    #1;
    vectors++;
    if (mode !== 3'd0) begin miscompares++; $display("FAIL async_reset_mode: got %0d expected 0", mode); end
    vectors++;
    if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL async_reset_tick: got %b expected 0", frame_tick); end
    x = 8'd16; y = 8'd0; #1;
    vectors++;
    if (color !== 16'h0080) begin miscompares++; $display("FAIL reset_color_16_0: got %h expected 0080", color); end
    @(negedge clk); resn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    int ticks;
    int stray;
    ticks = 0; stray = 0;
    @(negedge clk); x = 8'd1; y = 8'd1;
    // Two 240x60 frames keep the run short while exercising full lines
    for (int f = 0; f < 2; f++) begin
      for (int yy = 0; yy < 60; yy++) begin
        for (int xx = 0; xx < 240; xx++) begin
          @(negedge clk); x = 8'(xx); y = 8'(yy); #1;
          if (frame_tick === 1'b1) begin
            ticks++;
            if (x != 8'd0 || y != 8'd0) stray++;
          end
        end
      end
    end
    vectors++;
    if (ticks !== 2) begin miscompares++; $display("FAIL frame_ticks: got %0d expected 2", ticks); end
    vectors++;
    if (stray !== 0) begin miscompares++; $display("FAIL frame_tick_position: got %0d off-origin expected 0", stray); end
    @(negedge clk); x = 8'd5; y = 8'd5;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); x = 8'd0; y = 8'd0; #1;
      if (frame_tick === 1'b1) ticks++;
    end
    vectors++;
    if (ticks !== 1) begin miscompares++; $display("FAIL hold_origin_ticks: got %0d expected 1", ticks); end
    @(negedge clk); x = 8'd3; y = 8'd5;
  endtask

  task automatic test_scroll();
    logic [15:0] exp_x0;
    logic [15:0] exp_x254;
    press_prev();
    vectors++;
    if (mode !== 3'd4) begin miscompares++; $display("FAIL scroll_mode: got %0d expected 4", mode); end
    x = 8'd0; y = 8'd5; #1;
    vectors++;
    if (color !== 16'hFFFF) begin miscompares++; $display("FAIL scroll_pre_x0: got %h expected FFFF", color); end
    x = 8'd2; #1;
    vectors++;
    if (color !== 16'h0000) begin miscompares++; $display("FAIL scroll_pre_x2: got %h expected 0000", color); end
    for (int f = 0; f < 4; f++) begin
      @(negedge clk); x = 8'd0; y = 8'd0;
      @(negedge clk); x = 8'd0; y = 8'd5;
    end
`ifdef LCD_PATTERN_SCROLL_EN
    exp_x0   = 16'h0000;
    exp_x254 = 16'hFFFF;
`else
    exp_x0   = 16'hFFFF;
    exp_x254 = 16'h0000;
`endif
    #1;
    vectors++;
    if (color !== exp_x0) begin miscompares++; $display("FAIL scroll_post_x0: got %h expected %h", color, exp_x0); end
    x = 8'd254; #1;
    vectors++;
    if (color !== exp_x254) begin miscompares++; $display("FAIL scroll_post_x254: got %h expected %h", color, exp_x254); end
    x = 8'd0;
    press_next();
    press_prev();
    #1;
    vectors++;
    if (color !== 16'hFFFF) begin miscompares++; $display("FAIL scroll_reset_on_mode: got %h expected FFFF", color); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_debounce();
    test_simultaneous();
    test_patterns();
    test_reset_midframe();
    test_frame();
    test_scroll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the whole sequence needs well under this much time
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
